cmd_frame_parser: RTL and testbench
===================================

CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the byte/data width.
REQ-002 Parameter ADDR, default 4, SHALL set the register-address width.
REQ-003 Parameter TIMEOUT, default 1023, SHALL set the max idle cycles between bytes inside one frame (range 1..65535).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port CLK, input, 1: the single clock (REF_CLK domain).
REQ-006 Port RST, input, 1: reset, synchronous, active-high.
REQ-007 Port rx_data, input, WIDTH: synchronized received byte.
REQ-008 Port rx_valid, input, 1: one-cycle pulse, rx_data valid.
REQ-009 Port busy, input, 1: response path busy (ALU result pending or FIFO full).
REQ-010 Port wr_en, output, 1: register-file write strobe.
REQ-011 Port rd_en, output, 1: register-file read strobe.
REQ-012 Port addr, output, ADDR: register address.
REQ-013 Port wr_data, output, WIDTH: register write data.
REQ-014 Port alu_en, output, 1: ALU start strobe.
REQ-015 Port alu_fun, output, 4: ALU function code.
REQ-016 Port frame_err, output, 1: one-cycle error pulse.

Function
REQ-017 All outputs SHALL be registered; wr_en, rd_en, alu_en and frame_err SHALL be single-cycle pulses.
REQ-018 Command codes: 0xAA reg write (addr, data); 0xBB reg read (addr); 0xCC ALU with operands (A, B, fun); 0xDD ALU without operands (fun).
REQ-019 States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUN, WAIT_ISSUE.
REQ-020 IDLE: 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->OP_A, 0xDD->FUN; any other byte -> frame_err pulse next cycle, stay IDLE.
REQ-021 WR_ADDR: latch rx_data[ADDR-1:0] ->WR_DATA; WR_DATA byte -> wr_en=1, addr=latched, wr_data=byte one cycle after rx_valid, ->IDLE.
REQ-022 OP_A byte -> wr_en with addr=0, wr_data=byte next cycle, ->OP_B; OP_B byte -> wr_en with addr=1 next cycle, ->FUN.
REQ-023 RD_ADDR byte or FUN byte SHALL issue rd_en (addr=byte[ADDR-1:0]) or alu_en (alu_fun=byte[3:0]) one cycle after rx_valid when busy=0, then ->IDLE.
REQ-024 If busy=1 at that point, SHALL enter WAIT_ISSUE holding the pending command; issue in the cycle after busy is first sampled 0, then ->IDLE.
REQ-025 Writes (REQ-021/022) SHALL never be gated by busy.
REQ-026 rx_valid in WAIT_ISSUE: byte dropped, frame_err pulse, pending command kept.
REQ-027 Inter-byte counter SHALL clear on every accepted byte and count while in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUN; reaching TIMEOUT -> frame_err pulse, ->IDLE, partial frame discarded (OP_A write already issued stays).
REQ-028 Counter SHALL not run in IDLE or WAIT_ISSUE; WAIT_ISSUE has no timeout.
REQ-029 addr and wr_data SHALL hold last driven value when strobes are low; alu_fun holds last issued code.
REQ-030 rx_valid coinciding with timeout expiry: timeout wins, byte discarded.

Reset
REQ-031 RST=1 at a rising edge SHALL force IDLE, clear counter and pending command, and drive all outputs to 0 at that edge, including mid-frame and in WAIT_ISSUE.
REQ-032 rx_valid during RST SHALL be ignored.

Verification
REQ-033 AA,05,3C with busy=0 -> one wr_en, addr=5, wr_data=0x3C one cycle after last byte; no other strobes.
REQ-034 CC,12,34,02 -> wr_en addr=0 data 0x12, wr_en addr=1 data 0x34, then alu_en alu_fun=2.
REQ-035 BB,07 with busy=1 for 20 cycles -> no rd_en until cycle after busy falls, then one rd_en addr=7; extra byte during wait -> frame_err, rd_en still issued.
REQ-036 Byte 0x55 in IDLE -> frame_err pulse, state IDLE; following DD,08 -> alu_en alu_fun=8.
REQ-037 TIMEOUT=16: AA,03 then silence 16 cycles -> frame_err, no wr_en; subsequent AA,03,FF -> wr_en data 0xFF.
REQ-038 RST asserted after CC,12 -> outputs 0, IDLE; next bytes 34,02 -> frame_err on 0x34 (unknown), 0x02 frame_err, no alu_en.

Source files
------------

// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: decodes serial command frames into register-file
// write/read strobes and ALU start strobes, with per-byte timeout.
module cmd_frame_parser #(
  parameter int WIDTH   = 8,
  parameter int ADDR    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  input  logic             busy,
  output logic             wr_en,
  output logic             rd_en,
  output logic [ADDR-1:0]  addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             alu_en,
  output logic [3:0]       alu_fun,
  output logic             frame_err
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR,
    OP_A, OP_B, FUN, WAIT_ISSUE
  } state_t;

  localparam logic [WIDTH-1:0] C_WR  = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] C_RD  = WIDTH'(8'hBB);
  localparam logic [WIDTH-1:0] C_ALU = WIDTH'(8'hCC);
  localparam logic [WIDTH-1:0] C_FUN = WIDTH'(8'hDD);
  localparam logic [15:0]      TMO   = 16'(TIMEOUT);

  state_t           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [ADDR-1:0]  lat_q, lat_d;
  logic             prd_q, prd_d;
  logic [ADDR-1:0]  paddr_q, paddr_d;
  logic [3:0]       pfun_q, pfun_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic             alu_q, alu_d;
  logic             err_q, err_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0] wdat_q, wdat_d;
  logic [3:0]       fun_q, fun_d;
  logic             counting;
  logic             expired;

  assign wr_en     = wr_q;
  assign rd_en     = rd_q;
  assign alu_en    = alu_q;
  assign frame_err = err_q;
  assign addr      = addr_q;
  assign wr_data   = wdat_q;
  assign alu_fun   = fun_q;

  // The frame expires once TMO full idle cycles have elapsed; a byte
  // arriving on that same edge loses to the timeout.
  assign counting = (state_q != IDLE) && (state_q != WAIT_ISSUE);
  assign expired  = counting && (cnt_q == TMO);

  // Next-state, strobe and output-hold logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    lat_d   = lat_q;
    prd_d   = prd_q;
    paddr_d = paddr_q;
    pfun_d  = pfun_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    alu_d   = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    fun_d   = fun_q;
    if (expired) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      if (counting && !rx_valid) begin
        cnt_d = 16'(cnt_q + 16'd1);
      end
      case (state_q)
        IDLE: begin
          if (rx_valid) begin
            unique case (1'b1)
              rx_data == C_WR:  state_d = WR_ADDR;
              rx_data == C_RD:  state_d = RD_ADDR;
              rx_data == C_ALU: state_d = OP_A;
              rx_data == C_FUN: state_d = FUN;
              default:          err_d   = 1'b1;
            endcase
          end
        end
        WR_ADDR: begin
          if (rx_valid) begin
            lat_d   = rx_data[ADDR-1:0];
            state_d = WR_DATA;
          end
        end
        WR_DATA: begin
          if (rx_valid) begin
            wr_d    = 1'b1;
            addr_d  = lat_q;
            wdat_d  = rx_data;
            state_d = IDLE;
          end
        end
        OP_A: begin
          if (rx_valid) begin
            wr_d    = 1'b1;
            addr_d  = '0;
            wdat_d  = rx_data;
            state_d = OP_B;
          end
        end
        OP_B: begin
          if (rx_valid) begin
            wr_d    = 1'b1;
            addr_d  = ADDR'(1);
            wdat_d  = rx_data;
            state_d = FUN;
          end
        end
        RD_ADDR, FUN: begin
          if (rx_valid) begin
            prd_d   = (state_q == RD_ADDR);
            paddr_d = rx_data[ADDR-1:0];
            pfun_d  = rx_data[3:0];
            if (busy) begin
              state_d = WAIT_ISSUE;
            end else begin
              state_d = IDLE;
              if (state_q == RD_ADDR) begin
                rd_d   = 1'b1;
                addr_d = rx_data[ADDR-1:0];
              end else begin
                alu_d = 1'b1;
                fun_d = rx_data[3:0];
              end
            end
          end
        end
        WAIT_ISSUE: begin
          err_d = rx_valid;
          if (!busy) begin
            state_d = IDLE;
            if (prd_q) begin
              rd_d   = 1'b1;
              addr_d = paddr_q;
            end else begin
              alu_d = 1'b1;
              fun_d = pfun_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      prd_q   <= 1'b0;
      paddr_q <= '0;
      pfun_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      alu_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      fun_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      prd_q   <= prd_d;
      paddr_q <= paddr_d;
      pfun_q  <= pfun_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      fun_q   <= fun_d;
    end
  end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// tb_cmd_frame_parser: directed vector table, hand-written corner
// sequences and random frames checked against a frame-level model.
module tb_cmd_frame_parser;
  localparam int W  = 8;
  localparam int A  = 4;
  localparam int TO = 16;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         busy = 1'b0;
  logic         wr_en, rd_en, alu_en, frame_err;
  logic [A-1:0] addr;
  logic [W-1:0] wr_data;
  logic [3:0]   alu_fun;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  cmd_frame_parser #(.WIDTH(W), .ADDR(A), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wr_data(wr_data), .alu_en(alu_en), .alu_fun(alu_fun),
    .frame_err(frame_err)
  );

  // Frame-level reference: collected bytes, idle gap, pending issue.
  bit         m_wr, m_rd, m_alu, m_err;
  logic [3:0] m_addr = '0;
  logic [7:0] m_wd = '0;
  logic [3:0] m_fun = '0;
  logic [7:0] fq[$];
  int         gap = 0;
  bit         p_v = 0, p_rd = 0;
  logic [7:0] p_val = '0;

  function automatic bit is_cmd(input logic [7:0] d);
    return d == 8'hAA || d == 8'hBB || d == 8'hCC || d == 8'hDD;
  endfunction

  task automatic m_issue(input bit rd, input logic [7:0] v, input bit b);
    if (b) begin
      p_v = 1; p_rd = rd; p_val = v;
    end else if (rd) begin
      m_rd = 1; m_addr = v[3:0];
    end else begin
      m_alu = 1; m_fun = v[3:0];
    end
  endtask

  task automatic m_write(input logic [3:0] a, input logic [7:0] v);
    m_wr = 1; m_addr = a; m_wd = v;
  endtask

  task automatic m_step(input bit r, input bit v, input logic [7:0] d,
                        input bit b);
    int n;
    m_wr = 0; m_rd = 0; m_alu = 0; m_err = 0;
    if (r) begin
      m_addr = '0; m_wd = '0; m_fun = '0;
      fq.delete(); gap = 0; p_v = 0;
    end else if (p_v) begin
      if (v) m_err = 1;
      if (!b) begin
        p_v = 0;
        m_issue(p_rd, p_val, 1'b0);
      end
    end else if (fq.size() != 0 && gap == TO) begin
      m_err = 1; fq.delete(); gap = 0;
    end else if (v) begin
      gap = 0;
      if (fq.size() == 0) begin
        if (is_cmd(d)) fq.push_back(d);
        else m_err = 1;
      end else begin
        fq.push_back(d);
        n = fq.size();
        case (fq[0])
          8'hAA: if (n == 3) begin
            m_write(fq[1][3:0], fq[2]); fq.delete();
          end
          8'hBB: begin m_issue(1'b1, fq[1], b); fq.delete(); end
          8'hDD: begin m_issue(1'b0, fq[1], b); fq.delete(); end
          default: begin
            if (n == 2) m_write(4'd0, fq[1]);
            else if (n == 3) m_write(4'd1, fq[2]);
            else begin m_issue(1'b0, fq[3], b); fq.delete(); end
          end
        endcase
      end
    end else if (fq.size() != 0) begin
      gap++;
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] d,
                      input bit b, input string tag);
    RST = r; rx_valid = v; rx_data = d; busy = b;
    @(posedge CLK);
    m_step(r, v, d, b);
    #1;
    checks++;
    if ({wr_en, rd_en, alu_en, frame_err, addr, wr_data, alu_fun} !==
        {m_wr, m_rd, m_alu, m_err, m_addr, m_wd, m_fun}) begin
      errors++;
      $display("FAIL %s: got wr=%b rd=%b alu=%b err=%b a=%h d=%h f=%h exp wr=%b rd=%b alu=%b err=%b a=%h d=%h f=%h",
               tag, wr_en, rd_en, alu_en, frame_err, addr, wr_data, alu_fun,
               m_wr, m_rd, m_alu, m_err, m_addr, m_wd, m_fun);
    end
  endtask

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  typedef struct {
    bit r, v; logic [7:0] d; bit b;
    bit wr, rd, alu, err;
    logic [3:0] a; logic [7:0] wd; logic [3:0] f;
  } vec_t;
  vec_t tv[$];

  task automatic add(input bit r, v, input logic [7:0] d, input bit b,
                     input bit wr, rd, alu, err, input logic [3:0] a,
                     input logic [7:0] wd, input logic [3:0] f);
    vec_t e;
    e.r = r; e.v = v; e.d = d; e.b = b;
    e.wr = wr; e.rd = rd; e.alu = alu; e.err = err;
    e.a = a; e.wd = wd; e.f = f;
    tv.push_back(e);
  endtask

  initial begin
    int ec, rc, wc, first;
    bit bsy, r, v;
    int sil;
    logic [7:0] d;

    //  r v  d     b  wr rd alu err a  wd     f
    add(1,1, 8'hAA,0, 0, 0, 0,  0, 0, 8'h00, 0);
    add(0,1, 8'hAA,0, 0, 0, 0,  0, 0, 8'h00, 0);
    add(0,1, 8'h05,1, 0, 0, 0,  0, 0, 8'h00, 0);
    add(0,1, 8'h3C,1, 1, 0, 0,  0, 5, 8'h3C, 0);
    add(0,0, 8'h00,0, 0, 0, 0,  0, 5, 8'h3C, 0);
    add(0,1, 8'hCC,0, 0, 0, 0,  0, 5, 8'h3C, 0);
    add(0,1, 8'h12,0, 1, 0, 0,  0, 0, 8'h12, 0);
    add(0,1, 8'h34,0, 1, 0, 0,  0, 1, 8'h34, 0);
    add(0,1, 8'h02,0, 0, 0, 1,  0, 1, 8'h34, 2);
    add(0,0, 8'h00,0, 0, 0, 0,  0, 1, 8'h34, 2);
    add(0,1, 8'h55,0, 0, 0, 0,  1, 1, 8'h34, 2);
    add(0,1, 8'hDD,0, 0, 0, 0,  0, 1, 8'h34, 2);
    add(0,1, 8'h08,0, 0, 0, 1,  0, 1, 8'h34, 8);
    add(0,0, 8'h00,0, 0, 0, 0,  0, 1, 8'h34, 8);
    add(0,1, 8'hBB,0, 0, 0, 0,  0, 1, 8'h34, 8);
    add(0,1, 8'h07,0, 0, 1, 0,  0, 7, 8'h34, 8);
    add(0,0, 8'h00,0, 0, 0, 0,  0, 7, 8'h34, 8);

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].r, tv[i].v, tv[i].d, tv[i].b, "vec_model");
      checks++;
      if ({wr_en, rd_en, alu_en, frame_err, addr, wr_data, alu_fun} !==
          {tv[i].wr, tv[i].rd, tv[i].alu, tv[i].err, tv[i].a, tv[i].wd,
           tv[i].f}) begin
        errors++;
        $display("FAIL vec%0d: got wr=%b rd=%b alu=%b err=%b a=%h d=%h f=%h",
                 i, wr_en, rd_en, alu_en, frame_err, addr, wr_data, alu_fun);
      end
    end

    // Read held off by busy for 20 cycles, stray byte mid-wait.
    step(0, 1, 8'hBB, 0, "busy_bb");
    step(0, 1, 8'h07, 1, "busy_07");
    ec = 0; rc = 0;
    for (int i = 0; i < 19; i++) begin
      step(0, i == 5, 8'h99, 1, "busy_wait");
      ec += int'(frame_err); rc += int'(rd_en);
    end
    check("busy_rd_held", rc, 0);
    check("busy_extra_err", ec, 1);
    step(0, 0, 8'h00, 0, "busy_release");
    check("busy_rd_issue", int'(rd_en), 1);
    check("busy_rd_addr", int'(addr), 7);
    step(0, 0, 8'h00, 0, "busy_after");
    check("busy_rd_pulse", int'(rd_en), 0);

    // Timeout after AA,03 then silence; recovery frame.
    step(0, 1, 8'hAA, 0, "to_aa");
    step(0, 1, 8'h03, 0, "to_03");
    ec = 0; wc = 0; first = -1;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 8'h00, 0, "to_idle");
      if (frame_err && first < 0) first = i;
      ec += int'(frame_err); wc += int'(wr_en);
    end
    check("to_err_count", ec, 1);
    check("to_err_cycle", first, TO);
    check("to_no_wr", wc, 0);
    step(0, 1, 8'hAA, 0, "to2_aa");
    step(0, 1, 8'h03, 0, "to2_03");
    step(0, 1, 8'hFF, 0, "to2_ff");
    check("to2_wr", int'(wr_en), 1);
    check("to2_data", int'(wr_data), 8'hFF);

    // Longest accepted gap, then a byte on the expiry edge.
    step(0, 1, 8'hAA, 0, "gap_aa");
    step(0, 1, 8'h04, 0, "gap_04");
    for (int i = 0; i < TO - 1; i++) step(0, 0, 8'h00, 0, "gap_idle");
    step(0, 1, 8'h5A, 0, "gap_last");
    check("gap_ok_wr", int'(wr_en), 1);
    step(0, 1, 8'hAA, 0, "exp_aa");
    step(0, 1, 8'h04, 0, "exp_04");
    for (int i = 0; i < TO; i++) step(0, 0, 8'h00, 0, "exp_idle");
    step(0, 1, 8'h6B, 0, "exp_byte");
    check("exp_err", int'(frame_err), 1);
    check("exp_no_wr", int'(wr_en), 0);

    // Reset mid-frame with rx_valid asserted.
    step(0, 1, 8'hCC, 0, "rst_cc");
    step(0, 1, 8'h12, 0, "rst_12");
    step(1, 1, 8'h34, 0, "rst_on");
    check("rst_outs", int'({wr_en, rd_en, alu_en, frame_err, addr,
                            wr_data, alu_fun}), 0);
    step(0, 1, 8'h34, 0, "rst_34");
    check("rst_34_err", int'(frame_err), 1);
    step(0, 1, 8'h02, 0, "rst_02");
    check("rst_02_err", int'(frame_err), 1);
    check("rst_no_alu", int'(alu_en), 0);

    // Reset while a read is pending.
    step(0, 1, 8'hBB, 0, "rstw_bb");
    step(0, 1, 8'h09, 1, "rstw_09");
    step(1, 0, 8'h00, 1, "rstw_on");
    rc = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'h00, 0, "rstw_idle");
      rc += int'(rd_en);
    end
    check("rstw_no_rd", rc, 0);

    // Random traffic against the model.
    bsy = 0; sil = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) bsy = ~bsy;
      if (sil > 0) begin
        sil--; v = 0;
      end else begin
        if ($urandom_range(0, 39) == 0) sil = $urandom_range(12, 20);
        v = ($urandom_range(0, 1) == 1);
      end
      case ($urandom_range(0, 5))
        0: d = 8'hAA;
        1: d = 8'hBB;
        2: d = 8'hCC;
        3: d = 8'hDD;
        default: d = 8'($urandom);
      endcase
      step(r, v, d, bsy, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
